// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage that feeds the instruction decoder. It walks the PC, issues
// word fetches to instruction memory over req/gnt/rvalid, buffers the returned
// words together with their PCs in a small FIFO, and presents them to decode
// over a valid/ready handshake. A redirect (branch/jump/trap) flushes the
// buffer and marks every in-flight response for discard.
//
// Parameters
//   RESET_PC    PC of the first fetch after reset (word aligned).
//   FIFO_DEPTH  instruction buffer entries (>= 2, power of two).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req / imem_addr       fetch request and word address (to memory)
//   imem_gnt                   request accepted this cycle
//   imem_rvalid / imem_rdata   in-order response (>= 1 cycle after grant)
//   redirect_valid/redirect_pc single-cycle PC change, low two bits ignored
//   out_valid / out_ready      decode handshake
//   out_instr / out_pc         FIFO head (zero while out_valid is low)
//
// Handshakes: a memory request transfers in a cycle with imem_req & imem_gnt;
// imem_addr only changes after a grant or a redirect, and a redirect withdraws
// any ungranted request. A decode transfer happens in a cycle with
// out_valid & out_ready; out_instr/out_pc hold while out_valid & !out_ready.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  // Counter width holds 0..FIFO_DEPTH; pointer width indexes the FIFO.
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_ZERO     = '0;
  localparam logic [PW-1:0] P_ONE      = PW'(1);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic [CW:0] credit_used;
  logic        grant;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  // The low two bits of redirect_pc are deliberately dropped.
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign redirect_target     = {redirect_pc[31:2], 2'b00};

  // Every slot is either sitting in the FIFO or still owed by memory
  // (including responses that will be discarded), so limiting the sum to
  // FIFO_DEPTH guarantees a response always has somewhere to land.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};

  // rst_n gates the request so nothing is presented to memory while reset is
  // held; the first request appears in the first cycle after release.
  assign imem_req  = rst_n & ~redirect_valid & (credit_used < CREDIT_MAX);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req & imem_gnt;

  // A redirect cycle drops any response arriving with it and ignores a pop.
  assign push = imem_rvalid & ~redirect_valid & (discard_q == C_ZERO);
  assign pop  = out_valid & out_ready & ~redirect_valid;

  assign out_valid = (count_q != C_ZERO);
  assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + (grant ? C_ONE : C_ZERO)
                                  - (imem_rvalid ? C_ONE : C_ZERO);
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      // Everything still owed by memory after this cycle belongs to the old
      // stream. Earlier pending discards are already part of outstanding, so
      // back-to-back redirects accumulate without extra bookkeeping.
      discard_d  = outstanding_d;
      count_d    = C_ZERO;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid && (discard_q != C_ZERO)) begin
        discard_d = discard_q - C_ONE;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + P_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + P_ONE;
      end
      count_d = count_q + (push ? C_ONE : C_ZERO) - (pop ? C_ONE : C_ZERO);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= C_ZERO;
      discard_q     <= C_ZERO;
      count_q       <= C_ZERO;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Buffer storage needs no reset: out_instr/out_pc are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outstanding_q != C_ZERO))
    else $error("imem_rvalid received with no request outstanding");

  push_has_room: assert property (
    @(posedge clk) disable iff (!rst_n)
    push |-> ((count_q != CW'(FIFO_DEPTH)) || pop))
    else $error("instruction buffer overflow");

  fetch_addr_aligned: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_req |-> (imem_addr[1:0] == 2'b00))
    else $error("fetch address not word aligned");

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  // Second instance exercising the address wrap.
  logic        imem_req2, imem_gnt2, imem_rvalid2;
  logic [31:0] imem_addr2, imem_rdata2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        out_valid2, out_ready2;
  logic [31:0] out_instr2, out_pc2;

  int checks = 0;
  int passed = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_pc(out_pc2)
  );

  // ---------------------------------------------------------------------------
  // Memory model: grants when gnt_en, answers in order lat cycles later.
  // Inputs change at negedge+1; tests drive at negedge+0 and sample at +3.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
  endfunction

  int          lat = 1;
  logic        gnt_en;
  int          cyc = 0;
  int          grant_cnt = 0;
  logic [31:0] addr_q[$];
  int          due_q[$];
  logic [31:0] gaddr_q[$];
  logic [31:0] addr2_q[$];
  int          due2_q[$];

  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    imem_gnt2 = 1'b1; imem_rvalid2 = 1'b0; imem_rdata2 = '0;
    redirect_valid2 = 1'b0; redirect_pc2 = '0; out_ready2 = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(addr_q[0]);
        void'(addr_q.pop_front()); void'(due_q.pop_front());
      end else begin
        imem_rvalid = 1'b0; imem_rdata = '0;
      end
      imem_gnt = gnt_en;
      if (imem_req && imem_gnt) begin
        addr_q.push_back(imem_addr); due_q.push_back(cyc + lat);
        gaddr_q.push_back(imem_addr); grant_cnt++;
      end
      if (due2_q.size() > 0 && due2_q[0] <= cyc) begin
        imem_rvalid2 = 1'b1; imem_rdata2 = mem_word(addr2_q[0]);
        void'(addr2_q.pop_front()); void'(due2_q.pop_front());
      end else begin
        imem_rvalid2 = 1'b0; imem_rdata2 = '0;
      end
      if (imem_req2 && imem_gnt2) begin
        addr2_q.push_back(imem_addr2); due2_q.push_back(cyc + 1);
      end
    end
  end

  // Holds reset long enough for every pending response to drain, then
  // releases it at a negedge; the caller continues in the first live cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1; gnt_en = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    lat = 1;
    repeat (3) @(negedge clk);
    #3;
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", out_instr); else passed++;
    checks++; if (out_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", out_pc); else passed++;
    checks++; if (imem_addr2 !== 32'hFFFF_FFF8) $display("FAIL reset_addr_wrapdut: got %h want fffffff8", imem_addr2); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    checks++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL first_addr: got %h want 0", imem_addr); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    int got;
    lat = 1;
    do_reset();
    exp_pc = 32'h0; got = 0;
    for (int i = 0; i < 40 && got < 6; i++) begin
      @(negedge clk); #3;
      if (out_valid) begin
        checks++; if (out_pc !== exp_pc) $display("FAIL stream_pc: got %h want %h", out_pc, exp_pc); else passed++;
        checks++; if (out_instr !== mem_word(exp_pc)) $display("FAIL stream_instr: got %h want %h", out_instr, mem_word(exp_pc)); else passed++;
        exp_pc += 32'd4; got++;
      end
    end
    checks++; if (got != 6) $display("FAIL stream_count: got %0d want 6", got); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, a1;
    lat = 1;
    do_reset();
    out_ready = 1'b0; grant_cnt = 0; gaddr_q.delete();
    repeat (8) @(negedge clk);
    #3;
    a0 = (gaddr_q.size() > 0) ? gaddr_q[0] : 32'hDEAD_BEEF;
    a1 = (gaddr_q.size() > 1) ? gaddr_q[1] : 32'hDEAD_BEEF;
    checks++; if (grant_cnt != 2) $display("FAIL bp_grants: got %0d want 2", grant_cnt); else passed++;
    checks++; if (a0 !== 32'h0) $display("FAIL bp_addr0: got %h want 0", a0); else passed++;
    checks++; if (a1 !== 32'h4) $display("FAIL bp_addr1: got %h want 4", a1); else passed++;
    checks++; if (imem_req !== 1'b0) $display("FAIL bp_req_low: got %b want 0", imem_req); else passed++;
    @(negedge clk); #3;
    checks++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", out_valid); else passed++;
    checks++; if (out_pc !== 32'h0) $display("FAIL bp_hold_pc: got %h want 0", out_pc); else passed++;
    @(negedge clk);
    out_ready = 1'b1;
    #3;
    checks++; if (out_pc !== 32'h0) $display("FAIL bp_rel_pc0: got %h want 0", out_pc); else passed++;
    checks++; if (out_instr !== mem_word(32'h0)) $display("FAIL bp_rel_instr0: got %h want %h", out_instr, mem_word(32'h0)); else passed++;
    @(negedge clk); #3;
    checks++; if (out_pc !== 32'h4) $display("FAIL bp_rel_pc1: got %h want 4", out_pc); else passed++;
    checks++; if (out_instr !== mem_word(32'h4)) $display("FAIL bp_rel_instr1: got %h want %h", out_instr, mem_word(32'h4)); else passed++;
    checks++; if (imem_req !== 1'b1) $display("FAIL bp_resume_req: got %b want 1", imem_req); else passed++;
    checks++; if (imem_addr !== 32'h8) $display("FAIL bp_resume_addr: got %h want 8", imem_addr); else passed++;
  endtask

  task automatic test_redirect();
    logic seen_req;
    logic done;
    lat = 3;
    do_reset();
    // Cycle 0 grants 0x0, cycle 1 grants 0x4; cycle 2 has both in flight.
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #3;
    checks++; if (imem_req !== 1'b0) $display("FAIL redir_req_low: got %b want 0", imem_req); else passed++;
    @(negedge clk);
    redirect_valid = 1'b0;
    seen_req = 1'b0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      #3;
      if (imem_req && !seen_req) begin
        seen_req = 1'b1;
        checks++; if (imem_addr !== 32'h100) $display("FAIL redir_addr: got %h want 100", imem_addr); else passed++;
      end
      if (out_valid) begin
        done = 1'b1;
        checks++; if (out_pc !== 32'h100) $display("FAIL redir_first_pc: got %h want 100", out_pc); else passed++;
        checks++; if (out_instr !== mem_word(32'h100)) $display("FAIL redir_first_instr: got %h want %h", out_instr, mem_word(32'h100)); else passed++;
      end
      @(negedge clk);
    end
    checks++; if (!done) $display("FAIL redir_timeout: got no output want pc 100"); else passed++;
    lat = 1;
  endtask

  task automatic test_redirect_collide();
    logic done;
    lat = 1;
    do_reset();
    // Cycle 1 carries the response for 0x0 and a high gnt.
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #3;
    checks++; if (imem_req !== 1'b0) $display("FAIL collide_req_low: got %b want 0", imem_req); else passed++;
    @(negedge clk);
    redirect_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      #3;
      if (out_valid) begin
        done = 1'b1;
        checks++; if (out_pc !== 32'h200) $display("FAIL collide_first_pc: got %h want 200", out_pc); else passed++;
        checks++; if (out_instr !== mem_word(32'h200)) $display("FAIL collide_first_instr: got %h want %h", out_instr, mem_word(32'h200)); else passed++;
      end
      @(negedge clk);
    end
    checks++; if (!done) $display("FAIL collide_timeout: got no output want pc 200"); else passed++;
  endtask

  task automatic test_back_to_back();
    logic done;
    int got;
    lat = 2;
    do_reset();
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    redirect_pc = 32'h0000_0402;
    @(negedge clk);
    redirect_valid = 1'b0;
    done = 1'b0; got = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      #3;
      if (out_valid) begin
        checks++; if (out_pc !== 32'h400 + 32'(got * 4)) $display("FAIL b2b_pc: got %h want %h", out_pc, 32'h400 + 32'(got * 4)); else passed++;
        got++;
        if (got == 3) done = 1'b1;
      end
      @(negedge clk);
    end
    checks++; if (!done) $display("FAIL b2b_timeout: got %0d outputs want 3", got); else passed++;
    lat = 1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    int got;
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
    do_reset();
    got = 0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      @(negedge clk); #3;
      if (out_valid2) begin
        checks++; if (out_pc2 !== exp_pc[got]) $display("FAIL wrap_pc: got %h want %h", out_pc2, exp_pc[got]); else passed++;
        checks++; if (out_instr2 !== mem_word(exp_pc[got])) $display("FAIL wrap_instr: got %h want %h", out_instr2, mem_word(exp_pc[got])); else passed++;
        got++;
      end
    end
    checks++; if (got != 3) $display("FAIL wrap_count: got %0d want 3", got); else passed++;
  endtask

  task automatic test_midreset();
    int got;
    lat = 2;
    do_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #3;
    checks++; if (imem_req !== 1'b0) $display("FAIL midrst_req: got %b want 0", imem_req); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_pc !== 32'h0) $display("FAIL midrst_pc: got %h want 0", out_pc); else passed++;
    checks++; if (out_instr !== 32'h0) $display("FAIL midrst_instr: got %h want 0", out_instr); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL midrst_addr: got %h want 0", imem_addr); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    checks++; if (imem_req !== 1'b1) $display("FAIL midrst_restart_req: got %b want 1", imem_req); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL midrst_restart_addr: got %h want 0", imem_addr); else passed++;
    got = 0;
    for (int i = 0; i < 30 && got < 2; i++) begin
      @(negedge clk); #3;
      if (out_valid) begin
        checks++; if (out_pc !== 32'(got * 4)) $display("FAIL midrst_out_pc: got %h want %h", out_pc, 32'(got * 4)); else passed++;
        checks++; if (out_instr !== mem_word(32'(got * 4))) $display("FAIL midrst_out_instr: got %h want %h", out_instr, mem_word(32'(got * 4))); else passed++;
        got++;
      end
    end
    checks++; if (got != 2) $display("FAIL midrst_count: got %0d want 2", got); else passed++;
    lat = 1;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b1; gnt_en = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collide();
    test_back_to_back();
    test_wrap();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Generates the PC sequence and issues word requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump/trap), which flushes buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset. Bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction buffer entries. Must be ≥2 and a power of two.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned; held stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  single-cycle pulse that changes the fetch PC.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  32  instruction word for the decoder.
- out_pc  out  32  PC of out_instr.

Behaviour:
Reset (asynchronous assert, synchronous release):
- fetch_pc=RESET_PC, resp_pc=RESET_PC.
- FIFO empty, outstanding=0, discard=0.
- imem_req=0, out_valid=0, out_instr=0, out_pc=0.
- First imem_req asserts in the first cycle after rst_n is high.

Requests and credit:
- imem_req=1 when (outstanding + fifo_count) < FIFO_DEPTH and redirect_valid=0.
- imem_addr = fetch_pc.
- On imem_req & imem_gnt: fetch_pc += 4 (modulo 2^32, so 0xFFFF_FFFC wraps to 0) and outstanding += 1.
- The credit rule guarantees the FIFO never overflows. No response is ever back-pressured.

Responses:
- On imem_rvalid: outstanding -= 1.
- If discard > 0: discard -= 1 and the data is dropped.
- Otherwise push {resp_pc, imem_rdata} into the FIFO and resp_pc += 4 (same wrap rule).
- imem_rvalid with outstanding=0 is a protocol violation and is flagged by an assertion.

Output:
- out_valid = FIFO not empty; out_instr/out_pc show the FIFO head.
- Pop on out_valid & out_ready.
- Latency: rvalid in cycle N gives out_valid in cycle N+1 when the FIFO was empty.
- Push and pop in the same cycle are both honoured, including at full and at one entry.
- out_instr/out_pc hold their value while out_valid=1 and out_ready=0.

Redirect (highest priority, cycle R):
- The FIFO is flushed; out_valid=0 in R+1. A pop in cycle R is ignored.
- fetch_pc and resp_pc are set to {redirect_pc[31:2], 2'b00}.
- discard := outstanding + (imem_req & imem_gnt in R ? 1 : 0) − (imem_rvalid in R ? 1 : 0). Any rvalid in R is dropped.
- imem_req=0 in R. The memory permits withdrawing an ungranted request.
- A new request to the target issues from R+1.
- Back-to-back redirects: the last one wins, and discard accumulates correctly.
- New requests may issue while discard > 0; credit includes the responses still to be discarded.

Counters:
- outstanding and discard are both ≤ FIFO_DEPTH, each sized clog2(FIFO_DEPTH+1) bits.

Test Plan:
- Reset, out_ready=1, gnt same cycle, rvalid 1 cycle later → out_pc stream 0x0,0x4,0x8,… with one instruction per cycle in steady state; out_instr matches the memory model.
- Hold out_ready=0 → exactly 2 grants (addr 0x0,0x4), then imem_req=0. Release out_ready → 0x0 then 0x4 in consecutive cycles, then fetch resumes at 0x8.
- Redirect to 0x0000_0103 with 2 requests outstanding → both responses dropped; next imem_addr=0x100; first out_pc=0x100.
- Redirect in the same cycle as gnt and rvalid → response dropped, granted request's data dropped; no stale PC ever reaches out_pc.
- RESET_PC=0xFFFF_FFF8 → out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert rst_n low mid-stream with a request outstanding → all outputs 0 immediately; after release fetch restarts at RESET_PC and the late rvalid of the aborted request is not presented.
